// File: rtl/main_control_pkg.sv
//==============================================================================
// main_control_pkg : opcodes, FSM state codes and ALUOp encodings shared by
//                    main_control and AluControl.  Rev 1.0
//==============================================================================
`default_nettype none

package main_control_pkg;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;

  typedef logic [3:0] state_t;

  localparam state_t c_st_fetch    = 4'd0;
  localparam state_t c_st_decode   = 4'd1;
  localparam state_t c_st_memadr   = 4'd2;
  localparam state_t c_st_memread  = 4'd3;
  localparam state_t c_st_memwb    = 4'd4;
  localparam state_t c_st_memwrite = 4'd5;
  localparam state_t c_st_execr    = 4'd6;
  localparam state_t c_st_execi    = 4'd7;
  localparam state_t c_st_aluwb    = 4'd8;
  localparam state_t c_st_beq      = 4'd9;
  localparam state_t c_st_jal      = 4'd10;
  localparam state_t c_st_illegal  = 4'd11;

  typedef enum logic [1:0] {
    c_aluop_add  = 2'b00,
    c_aluop_sub  = 2'b01,
    c_aluop_func = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == c_op_load) || (op == c_op_store);
  endfunction

endpackage : main_control_pkg

`default_nettype wire

// File: rtl/main_control_decode.sv
//==============================================================================
// main_control_decode : Moore output decode of the FSM state; zero only feeds
//                       the branch term of PCWrite.  Rev 1.0
//==============================================================================
`default_nettype none

module main_control_decode
  import main_control_pkg::*;
(
  input  logic [3:0] state,
  input  logic       zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       adr_src,
  output logic       illegal,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op
);

  ctrl_t ctrl;

  always_comb begin
    ctrl = '0;
    case (state)
      c_st_fetch: begin
        ctrl.ir_write   = 1'b1;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
        ctrl.pc_update  = 1'b1;
      end
      c_st_decode: begin
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b01;
      end
      c_st_memadr: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_src_b = 2'b01;
      end
      c_st_memread: ctrl.adr_src = 1'b1;
      c_st_memwb: begin
        ctrl.result_src = 2'b01;
        ctrl.reg_write  = 1'b1;
      end
      c_st_memwrite: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      c_st_execr: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_op    = c_aluop_func;
      end
      c_st_execi: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = c_aluop_func;
      end
      c_st_aluwb: ctrl.reg_write = 1'b1;
      c_st_beq: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_op    = c_aluop_sub;
        ctrl.branch    = 1'b1;
      end
      c_st_jal: begin
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b10;
        ctrl.pc_update = 1'b1;
      end
      c_st_illegal: ctrl.illegal = 1'b1;
      default: ctrl = '0;
    endcase
  end

  // zero reaches PCWrite combinationally so a branch resolves in the BEQ cycle
  assign pc_write   = ctrl.pc_update | (ctrl.branch & zero);
  assign ir_write   = ctrl.ir_write;
  assign reg_write  = ctrl.reg_write;
  assign mem_write  = ctrl.mem_write;
  assign adr_src    = ctrl.adr_src;
  assign illegal    = ctrl.illegal;
  assign result_src = ctrl.result_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;

endmodule : main_control_decode

`default_nettype wire

// File: rtl/main_control.sv
//==============================================================================
// main_control : multi-cycle RV32 main control FSM with configurable memory
//                wait states.  Rev 1.0
//==============================================================================
`default_nettype none

module main_control
  import main_control_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  output logic [1:0] ALUOp_out,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       illegal,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] state_out
);

  localparam logic [2:0] c_wait_last = (MEM_WAIT > 7) ? 3'd7 :
                                       (MEM_WAIT < 0) ? 3'd0 : 3'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [2:0] wait_q, wait_d;

  logic dec_pc_write, dec_ir_write, dec_reg_write, dec_mem_write, dec_illegal;

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_fetch:  state_d = c_st_decode;
      c_st_decode: begin
        if (is_mem_op(opcode))          state_d = c_st_memadr;
        else if (opcode == c_op_rtype)  state_d = c_st_execr;
        else if (opcode == c_op_itype)  state_d = c_st_execi;
        else if (opcode == c_op_branch) state_d = c_st_beq;
        else if (opcode == c_op_jal)    state_d = c_st_jal;
        else                            state_d = c_st_illegal;
      end
      c_st_memadr: begin
        if (opcode == c_op_load)       state_d = c_st_memread;
        else if (opcode == c_op_store) state_d = c_st_memwrite;
        else                           state_d = c_st_illegal;
      end
      c_st_memread:  if (wait_q == c_wait_last) state_d = c_st_memwb;
      c_st_memwrite: if (wait_q == c_wait_last) state_d = c_st_fetch;
      c_st_execr, c_st_execi, c_st_jal: state_d = c_st_aluwb;
      c_st_memwb, c_st_aluwb, c_st_beq, c_st_illegal: state_d = c_st_fetch;
      default: state_d = c_st_fetch;
    endcase
  end

  // Counter restarts on every state change, so each memory state starts at 0
  always_comb begin
    wait_d = 3'd0;
    if ((state_d == state_q) &&
        ((state_q == c_st_memread) || (state_q == c_st_memwrite))) begin
      wait_d = wait_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_st_fetch;
      wait_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  main_control_decode u_decode (
    .state      (state_q),
    .zero       (zero),
    .pc_write   (dec_pc_write),
    .ir_write   (dec_ir_write),
    .reg_write  (dec_reg_write),
    .mem_write  (dec_mem_write),
    .adr_src    (AdrSrc),
    .illegal    (dec_illegal),
    .result_src (ResultSrc),
    .alu_src_a  (ALUSrcA),
    .alu_src_b  (ALUSrcB),
    .alu_op     (ALUOp_out)
  );

  // Strobes are masked during reset because FETCH itself would raise IRWrite/PCWrite
  assign PCWrite   = dec_pc_write  & rst_n;
  assign IRWrite   = dec_ir_write  & rst_n;
  assign RegWrite  = dec_reg_write & rst_n;
  assign MemWrite  = dec_mem_write & rst_n;
  assign illegal   = dec_illegal   & rst_n;
  assign state_out = state_q;

endmodule : main_control

`default_nettype wire

// File: doc/main_control.md
MAIN_CONTROL -- requirements
Module: main_control

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0, meaning extra wait cycles (0..7) held in each memory-access state.
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port opcode  input  7  instr[6:0] from the instruction register.
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port ALUOp_out  output  2  ALUOp to AluControl: 00 add, 01 sub/compare, 10 decode func3/func7.
REQ-007 SHALL have ports PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, illegal  output  1 each  write strobes, address select and illegal-opcode flag.
REQ-008 SHALL have ports ResultSrc, ALUSrcA, ALUSrcB  output  2 each  datapath mux selects.
REQ-009 SHALL have port state_out  output  4  current state code, for debug.

Function
REQ-010 SHALL be a multi-cycle Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, ILLEGAL.
REQ-011 SHALL move FETCH->DECODE unconditionally.
REQ-012 SHALL decode in DECODE: 0000011/0100011->MEMADR; 0110011->EXECR; 0010011->EXECI; 1100011->BEQ; 1101111->JAL; any other opcode->ILLEGAL.
REQ-013 SHALL move MEMADR->MEMREAD for opcode 0000011 and MEMADR->MEMWRITE for 0100011.
REQ-014 SHALL move MEMREAD->MEMWB, EXECR/EXECI->ALUWB, JAL->ALUWB, and MEMWB/ALUWB/MEMWRITE/BEQ/ILLEGAL->FETCH.
REQ-015 SHALL hold MEMREAD and MEMWRITE for exactly 1+MEM_WAIT cycles using a wait counter that clears on every state entry.
REQ-016 SHALL assert MemWrite on every cycle spent in MEMWRITE.
REQ-017 SHALL drive outputs per state; every unlisted output is 0:
- FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, pc_update=1.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECR: ALUSrcA=10, ALUOp=10.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- BEQ: ALUSrcA=10, ALUOp=01, branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, pc_update=1.
- ILLEGAL: illegal=1.
REQ-018 SHALL compute PCWrite = pc_update OR (branch AND zero); this is the only combinational input-to-output path.
REQ-019 SHALL decode only the listed 7-bit opcodes; instr[1:0] != 11 SHALL be treated as illegal.

Reset
REQ-020 SHALL place the FSM in FETCH and clear the wait counter asynchronously while rst_n=0.
REQ-021 SHALL force PCWrite, IRWrite, RegWrite, MemWrite and illegal to 0 while rst_n=0.
REQ-022 SHALL, when reset is asserted mid-instruction, abandon the instruction with no further strobe, then run FETCH on the first clock after release.

Structure
REQ-023 SHALL take the opcode constants, the state enum (4-bit) and the ALUOp encodings from a shared package, also used by AluControl.
REQ-024 SHALL use one sub-module, main_control_decode, mapping state plus zero to the output vector; the next-state logic and counter stay in main_control.

Verification
REQ-025 Reset release, opcode=0110011 -> FETCH, DECODE, EXECR (ALUOp=10), ALUWB (RegWrite=1), FETCH: 4 cycles.
REQ-026 opcode=0000011, MEM_WAIT=2 -> MEMREAD held 3 cycles with AdrSrc=1; MEMWB RegWrite=1, ResultSrc=01; 7 cycles total.
REQ-027 opcode=1100011 -> BEQ ALUOp=01; PCWrite=1 when zero=1, PCWrite=0 when zero=0; toggling zero mid-cycle changes PCWrite the same cycle.
REQ-028 opcode=0100011, MEM_WAIT=0 -> exactly one MemWrite=1 cycle, RegWrite never 1.
REQ-029 opcode=1111111 -> illegal=1 for one cycle, then FETCH, no write strobe; rst_n pulled low during MEMWRITE -> MemWrite=0 immediately, state_out=FETCH.
